lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//  Load/store sequencer between the core's decode/ALU stage and the per-core L1 data cache port.
//  Turns the decoder's one-level load_control/store_control and funct3 into a req/ack transaction on the cache.
//  Stalls the core until the transaction completes.
//  Handles byte-lane steering, byte enables, load sign/zero extension and misalignment detection.
// PARAMETERS
//  XLEN            32   data/address width
//  TIMEOUT_CYCLES  255  max BUSY cycles before abort (LSU_TIMEOUT_EN only); 8-bit counter
// PORTS
//  clock         in   1     system clock, all state on rising edge
//  n_reset       in   1     asynchronous active-low reset
//  load_control  in   1     decoder: current instruction is a load
//  store_control in   1     decoder: current instruction is a store
//  funct3        in   3     instr[14:12]: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  addr          in   XLEN  effective address (ALU result)
//  store_data    in   XLEN  rs2 value
//  stall         out  1     hold PC/pipeline this cycle
//  load_valid    out  1     one-cycle: load_data valid, register file writes rd
//  load_data     out  XLEN  extended load result
//  err_access    out  1     one-cycle: misaligned or illegal funct3, access not issued
//  err_timeout   out  1     one-cycle: cache did not ack within TIMEOUT_CYCLES
//  mem_req       out  1     cache request, held until ack
//  mem_we        out  1     1 = write
//  mem_addr      out  XLEN  word-aligned address {addr[XLEN-1:2],2'b00}
//  mem_be        out  4     byte enables (writes; 4'b1111 for reads)
//  mem_wdata     out  XLEN  lane-replicated store data
//  mem_ack       in   1     cache completion, may assert any cycle mem_req=1
//  mem_rdata     in   XLEN  read word, valid with mem_ack
// BEHAVIOUR
//  Reset: state IDLE; stall, load_valid, err_*, mem_req, mem_we are 0.
//  Reset: mem_addr, mem_be, mem_wdata, load_data are 0.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//  IDLE, (load|store) legal: stall=1 combinationally.
//    Register addr, be, wdata, we, funct3; go to BUSY.
//  IDLE, (load|store) illegal: no request; err_access=1 same cycle; stall=0; stay IDLE.
//    Illegal = funct3 011/110/111 (store: also 100/101), W with addr[1:0]!=0, H/HU with addr[0]!=0.
//  load and store both high: load wins, store ignored.
//  BUSY: mem_req=1 and stall=1. Request fields stable until ack.
//    On mem_ack=1: capture extended mem_rdata into load_data, drop mem_req next cycle, go to DONE.
//  DONE: stall=0; load_valid=1 for loads only; go to IDLE unconditionally.
//    load_control still high in DONE is not a new request.
//  Minimum access is 3 cycles with ack in the first BUSY cycle: stall for 2 cycles, retire in cycle 3.
//  Byte enables: B=4'b0001<<addr[1:0]; H=4'b0011<<{addr[1],1'b0}; W=4'b1111.
//  Store lanes: B={4{d[7:0]}}, H={2{d[15:0]}}, W=d.
//  Load extract: B/BU take byte addr[1:0]; H/HU take half addr[1]; sign-extend B/H, zero-extend BU/HU.
//  mem_ack while not BUSY: ignored.
//  n_reset low mid-transaction: FSM to IDLE immediately, mem_req drops asynchronously, pending ack discarded.
// CONFIGURATION
//  LSU_TIMEOUT_EN defined:
//    Counter clears on entering BUSY, increments each BUSY cycle without ack.
//    On reaching TIMEOUT_CYCLES: drop mem_req, err_timeout=1 for one cycle, load_data=0, go to DONE.
//    load_valid still pulses so the core does not hang.
//  LSU_TIMEOUT_EN undefined: no counter, BUSY waits indefinitely, err_timeout tied to 0.
// STRUCTURE
//  lsu_pkg: state enum {IDLE,BUSY,DONE}, funct3 localparams, XLEN default.
//  lsu_align: combinational sub-module for be/wdata generation and load extraction/extension.
//  lsu_ctrl: FSM, request registers, timeout counter.
// TESTING
//  LW addr=0x100, ack in 1st BUSY cycle, rdata=0xDEADBEEF -> stall 2 cycles, load_valid with load_data=0xDEADBEEF.
//  LB addr=0x103, rdata=0x80xxxxxx -> load_data=0xFFFFFF80; LBU same -> 0x00000080.
//  SH addr=0x102 data=0x1234ABCD -> mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_we=1, no load_valid.
//  LW addr=0x101 -> err_access=1, mem_req never asserted, stall=0.
//  ack delayed 5 cycles, n_reset pulsed in 3rd BUSY cycle -> mem_req=0 at once, IDLE, later ack ignored.
//  LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> err_timeout after 4 BUSY cycles, load_data=0, core released.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// Shared constants for the load/store sequencer: FSM state codes,
// funct3 access-size encodings, the default data width and the
// legality check applied to every decoded access.
package lsu_ctrl_pkg;

  localparam int LSU_XLEN = 32;

  // FSM state codes (also visible on the debug state port)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // funct3 access sizes, instr[14:12]
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // An access is legal when funct3 names a size valid for its direction
  // and the address is naturally aligned for that size. Unsigned forms
  // only make sense for loads.
  function automatic logic access_legal(input logic       is_load,
                                        input logic [2:0] f3,
                                        input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      F3_BU:   ok = is_load;
      F3_HU:   ok = is_load & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Bus bundle between the core, the load/store sequencer and the L1 data
// cache port. The master modport is the sequencer's view; the slave
// modport is the environment (core + cache) view.
//
// Cache handshake: mem_req is the valid; mem_ack is the completion. While
// mem_req=1 the fields mem_we/mem_addr/mem_be/mem_wdata are stable. The
// cache may raise mem_ack in any cycle with mem_req=1, including the first;
// mem_rdata is only meaningful in that cycle. The transfer happens on the
// rising edge where mem_req and mem_ack are both 1, and mem_req is low the
// following cycle. mem_ack with mem_req=0 has no effect.
interface lsu_ctrl_if #(
  parameter int XLEN = 32
);

  // core side
  logic            load_control;
  logic            store_control;
  logic [2:0]      funct3;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] store_data;
  logic            stall;
  logic            load_valid;
  logic [XLEN-1:0] load_data;
  logic            err_access;
  logic            err_timeout;

  // cache side
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    input  load_control, store_control, funct3, addr, store_data,
    input  mem_ack, mem_rdata,
    output stall, load_valid, load_data, err_access, err_timeout,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output load_control, store_control, funct3, addr, store_data,
    output mem_ack, mem_rdata,
    input  stall, load_valid, load_data, err_access, err_timeout,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

endinterface

// File: rtl/lsu_ctrl_align.sv
// Byte-lane logic for a 4-byte data word: store byte enables and lane
// replication from the incoming request, and byte/half extraction with
// sign or zero extension of the returned read word.
module lsu_ctrl_align
  import lsu_ctrl_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: enable the addressed lanes and replicate data into every lane
  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_data_i;
    case (st_funct3_i)
      F3_B: begin
        st_be_o    = 4'b0001 << st_addr_lo_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      F3_H: begin
        st_be_o    = 4'b0011 << {st_addr_lo_i[1], 1'b0};
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_data_i;
      end
    endcase
  end

  // Load side: pick the addressed byte/half, then extend to a full word
  always_comb begin
    ld_byte = ld_rdata_i[7:0];
    case (ld_addr_lo_i)
      2'd0:    ld_byte = ld_rdata_i[7:0];
      2'd1:    ld_byte = ld_rdata_i[15:8];
      2'd2:    ld_byte = ld_rdata_i[23:16];
      default: ld_byte = ld_rdata_i[31:24];
    endcase
    ld_half = ld_addr_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_o = {24'h000000, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data_o = {16'h0000, ld_half};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer. Accepts a decoded load or store, checks size and
// alignment, issues one req/ack transaction on the L1 data cache port and
// stalls the core until the access retires (IDLE -> BUSY -> DONE -> IDLE).
// Optional feature macro LSU_TIMEOUT_EN: aborts a BUSY access that is not
// acknowledged within TIMEOUT_CYCLES cycles and flags err_timeout.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN = LSU_XLEN
`ifdef LSU_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic         clock,
  input  logic         n_reset,
  lsu_ctrl_if.master   bus,
  output logic [1:0]   dbg_state_o
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] ldata_q, ldata_d;
  logic [3:0]      be_q, be_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;

  logic            is_load, is_store, req_any, req_legal, start;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata, ld_ext;
  logic            tmo_hit;

  // A load has priority: a store flagged at the same time is dropped
  assign is_load   = bus.load_control;
  assign is_store  = bus.store_control & ~bus.load_control;
  assign req_any   = is_load | is_store;
  assign req_legal = access_legal(is_load, bus.funct3, bus.addr[1:0]);
  assign start     = (state_q == ST_IDLE) & req_any & req_legal;

  lsu_ctrl_align u_align (
    .st_funct3_i  (bus.funct3),
    .st_addr_lo_i (bus.addr[1:0]),
    .st_data_i    (bus.store_data),
    .st_be_o      (st_be),
    .st_wdata_o   (st_wdata),
    .ld_funct3_i  (f3_q),
    .ld_addr_lo_i (addr_q[1:0]),
    .ld_rdata_i   (bus.mem_rdata),
    .ld_data_o    (ld_ext)
  );

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       timed_out_q;

  // Last un-acked BUSY cycle allowed before the access is abandoned
  assign tmo_hit = (state_q == ST_BUSY) & ~bus.mem_ack & (tmo_cnt_q == TMO_LAST);

  // Count un-acked BUSY cycles; held at zero outside BUSY so each access starts fresh
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q != ST_BUSY)  tmo_cnt_d = 8'd0;
    else if (!bus.mem_ack)   tmo_cnt_d = tmo_cnt_q + 8'd1;
  end

  // Timeout counter and one-cycle abort flag (high exactly in the DONE cycle)
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      tmo_cnt_q   <= 8'd0;
      timed_out_q <= 1'b0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      timed_out_q <= tmo_hit;
    end
  end

  assign bus.err_timeout = timed_out_q;
`else
  assign tmo_hit         = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  // Next-state and request-register logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ldata_d = ldata_q;
    be_d    = be_q;
    we_d    = we_q;
    f3_d    = f3_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_BUSY;
          addr_d  = bus.addr;
          wdata_d = st_wdata;
          be_d    = is_load ? 4'b1111 : st_be;
          we_d    = is_store;
          f3_d    = bus.funct3;
        end
      end
      ST_BUSY: begin
        if (bus.mem_ack) begin
          ldata_d = ld_ext;
          state_d = ST_DONE;
        end else if (tmo_hit) begin
          ldata_d = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and request registers; reset aborts any access in flight
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      ldata_q <= '0;
      be_q    <= 4'b0000;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ldata_q <= ldata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
    end
  end

  // mem_req follows the state register directly so reset drops it at once
  assign bus.mem_req    = (state_q == ST_BUSY);
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = {addr_q[XLEN-1:2], 2'b00};
  assign bus.mem_be     = be_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.load_data  = ldata_q;
  assign bus.stall      = start | (state_q == ST_BUSY);
  assign bus.err_access = (state_q == ST_IDLE) & req_any & ~req_legal;
  assign bus.load_valid = (state_q == ST_DONE) & ~we_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed + lightly randomised bench for lsu_ctrl. Inputs change and
// outputs are sampled around the falling clock edge. Expected load results
// go into exp_q when an access is issued and are popped on load_valid.
module tb_lsu_ctrl;

  logic        clock;
  logic        n_reset;
  logic [1:0]  dbg_state;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_ld = 32'h0;

  lsu_ctrl_if #(.XLEN(32)) bus_if ();

`ifdef LSU_TIMEOUT_EN
  lsu_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .clock       (clock),
    .n_reset     (n_reset),
    .bus         (bus_if),
    .dbg_state_o (dbg_state)
  );
`else
  lsu_ctrl #(.XLEN(32)) dut (
    .clock       (clock),
    .n_reset     (n_reset),
    .bus         (bus_if),
    .dbg_state_o (dbg_state)
  );
`endif

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference load extension: shift the addressed lane down, then extend
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> {a[1:0], 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  // Reference store lanes
  function automatic logic [35:0] model_store(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] d);
    logic [3:0] be;
    logic [31:0] wd;
    case (f3)
      3'b000:  begin be = 4'b0001 << a[1:0];          wd = {4{d[7:0]}};  end
      3'b001:  begin be = a[1] ? 4'b1100 : 4'b0011;   wd = {2{d[15:0]}}; end
      default: begin be = 4'b1111;                    wd = d;            end
    endcase
    return {be, wd};
  endfunction

  // Driver: one legal access, cache acks after 'delay' un-acked BUSY cycles
  task automatic access(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input int delay, input string tag);
    logic [35:0] sm;
    logic        is_ld;
    is_ld = ld;
    sm = model_store(f3, a, d);
    if (is_ld) exp_q.push_back(model_load(f3, a, rd));
    @(negedge clock);
    bus_if.load_control  = ld;
    bus_if.store_control = st;
    bus_if.funct3        = f3;
    bus_if.addr          = a;
    bus_if.store_data    = d;
    #1;
    check({tag, ".idle_stall"}, bus_if.stall, 1'b1);
    check({tag, ".idle_req"}, bus_if.mem_req, 1'b0);
    check({tag, ".idle_err"}, bus_if.err_access, 1'b0);
    for (int i = 0; i < delay; i++) begin
      @(negedge clock); #1;
      check({tag, ".wait_req"}, bus_if.mem_req, 1'b1);
      check({tag, ".wait_stall"}, bus_if.stall, 1'b1);
      check({tag, ".wait_addr"}, bus_if.mem_addr, {a[31:2], 2'b00});
      check({tag, ".wait_tmo"}, bus_if.err_timeout, 1'b0);
    end
    @(negedge clock);
    bus_if.mem_ack   = 1'b1;
    bus_if.mem_rdata = rd;
    #1;
    check({tag, ".req"}, bus_if.mem_req, 1'b1);
    check({tag, ".stall"}, bus_if.stall, 1'b1);
    check({tag, ".we"}, bus_if.mem_we, st & ~ld);
    check({tag, ".addr"}, bus_if.mem_addr, {a[31:2], 2'b00});
    check({tag, ".be"}, bus_if.mem_be, is_ld ? 4'b1111 : sm[35:32]);
    if (!is_ld) check({tag, ".wdata"}, bus_if.mem_wdata, sm[31:0]);
    @(negedge clock);
    bus_if.mem_ack   = 1'b0;
    bus_if.mem_rdata = $urandom();
    #1;
    check({tag, ".done_stall"}, bus_if.stall, 1'b0);
    check({tag, ".done_req"}, bus_if.mem_req, 1'b0);
    check({tag, ".load_valid"}, bus_if.load_valid, is_ld);
    check({tag, ".done_tmo"}, bus_if.err_timeout, 1'b0);
    if (bus_if.load_valid) begin
      if (exp_q.size() == 0) check({tag, ".sb_empty"}, 32'd0, 32'd1);
      else begin
        last_ld = exp_q.pop_front();
        check({tag, ".load_data"}, bus_if.load_data, last_ld);
      end
    end
    @(negedge clock);
    bus_if.load_control  = 1'b0;
    bus_if.store_control = 1'b0;
    #1;
    check({tag, ".back_idle"}, dbg_state, 2'd0);
    check({tag, ".no_repeat"}, bus_if.mem_req, 1'b0);
  endtask

  // Driver: one illegal access, held for a cycle, then released
  task automatic bad_access(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input string tag);
    @(negedge clock);
    bus_if.load_control  = ld;
    bus_if.store_control = st;
    bus_if.funct3        = f3;
    bus_if.addr          = a;
    #1;
    check({tag, ".err"}, bus_if.err_access, 1'b1);
    check({tag, ".stall"}, bus_if.stall, 1'b0);
    check({tag, ".req"}, bus_if.mem_req, 1'b0);
    @(negedge clock);
    bus_if.load_control  = 1'b0;
    bus_if.store_control = 1'b0;
    #1;
    check({tag, ".req_after"}, bus_if.mem_req, 1'b0);
    check({tag, ".state"}, dbg_state, 2'd0);
    check({tag, ".err_clr"}, bus_if.err_access, 1'b0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    int          pick;
    n_reset              = 1'b0;
    bus_if.load_control  = 1'b0;
    bus_if.store_control = 1'b0;
    bus_if.funct3        = 3'b000;
    bus_if.addr          = 32'h0;
    bus_if.store_data    = 32'h0;
    bus_if.mem_ack       = 1'b0;
    bus_if.mem_rdata     = 32'h0;

    // reset state
    repeat (3) @(negedge clock);
    #1;
    check("rst.state", dbg_state, 2'd0);
    check("rst.stall", bus_if.stall, 1'b0);
    check("rst.load_valid", bus_if.load_valid, 1'b0);
    check("rst.err_access", bus_if.err_access, 1'b0);
    check("rst.err_timeout", bus_if.err_timeout, 1'b0);
    check("rst.mem_req", bus_if.mem_req, 1'b0);
    check("rst.mem_we", bus_if.mem_we, 1'b0);
    check("rst.mem_addr", bus_if.mem_addr, 32'h0);
    check("rst.mem_be", bus_if.mem_be, 4'h0);
    check("rst.mem_wdata", bus_if.mem_wdata, 32'h0);
    check("rst.load_data", bus_if.load_data, 32'h0);
    @(negedge clock);
    n_reset = 1'b1;

    // directed accesses
    access(1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, "lw_100");
    access(1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h8012_3456, 1, "lb_103");
    access(1, 0, 3'b100, 32'h0000_0103, 32'h0, 32'h8012_3456, 0, "lbu_103");
    access(1, 0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 2, "lh_102");
    access(1, 0, 3'b101, 32'h0000_0100, 32'h0, 32'h1234_F00D, 0, "lhu_100");
    access(1, 0, 3'b000, 32'h0000_0101, 32'h0, 32'h0000_7F00, 0, "lb_101_pos");
    access(0, 1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'h0, 0, "sh_102");
    access(0, 1, 3'b000, 32'h0000_0101, 32'hCAFE_F077, 32'h0, 3, "sb_101");
    access(0, 1, 3'b010, 32'h0000_0200, 32'h0BAD_F00D, 32'h0, 1, "sw_200");
    access(1, 1, 3'b010, 32'h0000_0304, 32'h5555_5555, 32'h0102_0304, 0, "ld_st_both");

    // illegal accesses
    bad_access(1, 0, 3'b010, 32'h0000_0101, "lw_mis");
    bad_access(1, 0, 3'b001, 32'h0000_0103, "lh_mis");
    bad_access(0, 1, 3'b010, 32'h0000_0202, "sw_mis");
    bad_access(1, 0, 3'b011, 32'h0000_0100, "ld_f3_011");
    bad_access(0, 1, 3'b100, 32'h0000_0100, "st_f3_100");
    bad_access(0, 1, 3'b101, 32'h0000_0100, "st_f3_101");

    // stray ack while idle
    @(negedge clock);
    bus_if.mem_ack   = 1'b1;
    bus_if.mem_rdata = 32'hFFFF_FFFF;
    #1;
    check("stray.req", bus_if.mem_req, 1'b0);
    @(negedge clock);
    bus_if.mem_ack = 1'b0;
    #1;
    check("stray.load_valid", bus_if.load_valid, 1'b0);
    check("stray.state", dbg_state, 2'd0);
    check("stray.load_data", bus_if.load_data, last_ld);

    // reset in the 3rd BUSY cycle of an access whose ack would come late
    @(negedge clock);
    bus_if.load_control = 1'b1;
    bus_if.funct3       = 3'b010;
    bus_if.addr         = 32'h0000_0400;
    #1;
    check("rstmid.issue", bus_if.stall, 1'b1);
    repeat (3) begin
      @(negedge clock); #1;
      check("rstmid.busy_req", bus_if.mem_req, 1'b1);
    end
    bus_if.load_control = 1'b0;
    n_reset = 1'b0;
    #1;
    check("rstmid.req_drop", bus_if.mem_req, 1'b0);
    check("rstmid.state", dbg_state, 2'd0);
    check("rstmid.stall", bus_if.stall, 1'b0);
    @(negedge clock);
    n_reset = 1'b1;
    @(negedge clock);
    bus_if.mem_ack   = 1'b1;
    bus_if.mem_rdata = 32'h1111_2222;
    #1;
    check("rstmid.late_req", bus_if.mem_req, 1'b0);
    @(negedge clock);
    bus_if.mem_ack = 1'b0;
    #1;
    check("rstmid.late_lv", bus_if.load_valid, 1'b0);
    check("rstmid.late_ld", bus_if.load_data, 32'h0);
    check("rstmid.late_state", dbg_state, 2'd0);

    // randomised legal loads and stores
    for (int n = 0; n < 8; n++) begin
      pick = $urandom_range(0, 4);
      case (pick)
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        default: f3 = 3'b101;
      endcase
      a = {20'h0, 10'($urandom_range(0, 1023)), 2'b00} | 32'($urandom_range(0, 3));
      if (f3[0]) a[0] = 1'b0;
      if (f3 == 3'b010) a[1:0] = 2'b00;
      if (n[0] && !f3[2])
        access(0, 1, f3, a, $urandom(), 32'h0, $urandom_range(0, 2), "rnd_st");
      else
        access(1, 0, f3, a, 32'h0, $urandom(), $urandom_range(0, 2), "rnd_ld");
    end

`ifdef LSU_TIMEOUT_EN
    // no ack: abort after 4 BUSY cycles, load still retires with zero data
    exp_q.push_back(32'h0);
    @(negedge clock);
    bus_if.load_control = 1'b1;
    bus_if.funct3       = 3'b010;
    bus_if.addr         = 32'h0000_0500;
    #1;
    check("tmo.issue", bus_if.stall, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); #1;
      check("tmo.busy_req", bus_if.mem_req, 1'b1);
      check("tmo.busy_err", bus_if.err_timeout, 1'b0);
    end
    @(negedge clock); #1;
    check("tmo.err", bus_if.err_timeout, 1'b1);
    check("tmo.req", bus_if.mem_req, 1'b0);
    check("tmo.stall", bus_if.stall, 1'b0);
    check("tmo.load_valid", bus_if.load_valid, 1'b1);
    if (exp_q.size() != 0) check("tmo.load_data", bus_if.load_data, exp_q.pop_front());
    @(negedge clock);
    bus_if.load_control = 1'b0;
    #1;
    check("tmo.err_clr", bus_if.err_timeout, 1'b0);
    check("tmo.state", dbg_state, 2'd0);
`else
    // without the timeout feature a slow cache is simply waited for
    access(1, 0, 3'b010, 32'h0000_0500, 32'h0, 32'h7654_3210, 12, "slow_lw");
`endif

    check("sb.drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
